utmi_tx_arbiter: RTL and testbench
==================================

// Module: utmi_tx_arbiter
// PURPOSE
//  Packet-level arbiter sharing the single UTMI transmit byte path (tx_data/tx_valid into the TX FSM) among N endpoint requesters.
//  Grants one requester per packet (round-robin) and forwards its bytes with a ready/valid handshake.
//  Enforces an inter-packet idle gap and a maximum packet length.
//  Sits between the endpoint buffers and the TX FSM in the clk_60mhz domain.
// PARAMETERS
//  W        8     data byte width
//  N        4     number of requesters (2..8)
//  GAP_CYC  2     idle cycles forced after each packet (0 = none)
//  MAX_PKT  64    max bytes per packet before forced termination (>=1)
// PORTS
//  clk_60mhz  in   1    single clock; all logic on posedge
//  rst        in   1    asynchronous, active-high reset
//  ep_req     in   N    requester i has a packet pending
//  ep_data    in   N*W  packed per-requester byte; slice i = [i*W +: W]
//  ep_valid   in   N    byte valid per requester
//  ep_last    in   N    current byte is the last of the packet
//  ep_ready   out  N    byte accepted (only the granted bit may be 1)
//  ep_grant   out  N    one-hot registered grant
//  tx_data    out  W    byte to TX FSM
//  tx_valid   out  1    byte valid to TX FSM
//  tx_ready   in   1    TX FSM accepts byte
//  busy       out  1    state != IDLE
//  pkt_done   out  1    1-cycle pulse: packet ended normally
//  len_err    out  1    1-cycle pulse: packet truncated at MAX_PKT
// BEHAVIOUR
//  Reset: state IDLE, ep_grant=0, ep_ready=0, tx_valid=0, tx_data=0, busy=0, pkt_done=0, len_err=0, rr_ptr=0, byte_cnt=0.
//  States: IDLE -> XFER -> GAP -> IDLE (GAP skipped when GAP_CYC=0).
//  IDLE: if |ep_req, the winner is the first set bit at or after rr_ptr (wrapping mod N).
//   ep_grant is registered, so grant is high the cycle after ep_req is sampled; go to XFER.
//  XFER: tx_data/tx_valid are combinational muxes of the granted ep_data/ep_valid.
//   ep_ready[g] = tx_ready; all other ep_ready bits = 0.
//   A byte transfers on a cycle with tx_valid && tx_ready; byte_cnt increments by 1.
//   Transfer with ep_last[g]: next cycle ep_grant=0 and pkt_done=1; rr_ptr=(g+1) mod N; go to GAP or IDLE.
//   Transfer of byte number MAX_PKT with ep_last=0: the byte is forwarded; next cycle ep_grant=0 and len_err=1; rr_ptr advances as above; go to GAP or IDLE.
//   The requester discards the rest of the packet on the grant drop.
//   ep_last on byte MAX_PKT counts as a normal end (pkt_done, not len_err).
//   ep_req deasserting during XFER is ignored; the grant is held until the packet ends.
//   tx_ready low: no transfer; byte_cnt holds; ep_data stability is the requester's duty.
//  GAP: gap_cnt runs GAP_CYC cycles with tx_valid=0 and ep_req ignored, then IDLE.
//  Simultaneous requests are resolved purely by rr_ptr order.
//  Asynchronous rst in mid-packet returns to reset values immediately; the partial packet is abandoned.
//  Counter widths: byte_cnt = $clog2(MAX_PKT+1); gap_cnt = $clog2(GAP_CYC+1), minimum 1 bit.
// CONFIGURATION
//  UTMI_TX_EP0_PRIO_EN defined: in IDLE, ep_req[0] wins over all others regardless of rr_ptr.
//   rr_ptr is not updated after an ep0 packet.
//  Undefined: pure round-robin for all N requesters; ep0 has no special treatment.
// STRUCTURE
//  Package utmi_tx_arb_pkg holds:
//   - state enum (IDLE, XFER, GAP), 2-bit encoding
//   - width helper function for the counters
//  Sub-module utmi_rr_pick: combinational N-bit mask-based round-robin picker.
//   Inputs req and ptr; outputs one-hot gnt and gnt_idx.
//  Top level holds the FSM, counters, data mux and registered outputs.
// TESTING
//  1 ep_req=4'b0100, 3-byte packet, tx_ready=1 -> ep_grant=4'b0100 one cycle after req;
//    bytes out in order; pkt_done 1 cycle after byte 3; tx_valid=0 for 2 gap cycles.
//  2 ep_req=4'b1111 held, rr_ptr=0, 1-byte packets -> grant order ep0,ep1,ep2,ep3,ep0.
//  3 tx_ready low 5 cycles in mid-packet -> ep_ready[g]=0, byte_cnt held, no byte lost or duplicated.
//  4 MAX_PKT=8, 10-byte packet -> exactly 8 bytes forwarded; len_err pulse; grant drops; pkt_done stays 0.
//  5 rst pulse at byte 2 of 5 -> all outputs 0 asynchronously; after release rr_ptr=0, ep0 granted first.
//  6 ep_req=4'b1001 continuous, rr_ptr=3 -> with UTMI_TX_EP0_PRIO_EN only ep0 is granted;
//    without it grants alternate ep3, ep0, ep3.

Source files
------------

// File: rtl/utmi_tx_arb_pkg.sv
// Shared types and helpers for the UTMI transmit arbiter.
// Holds the arbiter state encoding and the counter width helper.

package utmi_tx_arb_pkg;

    // Arbiter packet-level states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Bits needed to hold the values 0..max_val, never less than one bit
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/utmi_rr_pick.sv
// Combinational mask-based round-robin picker.
// Picks the first set request bit at or after ptr, wrapping around to
// bit 0 when nothing at or above ptr is requesting.

module utmi_rr_pick
    import utmi_tx_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = cnt_width(N - 1)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] pick_src;

    // Mask off bits below ptr, fall back to the full request vector,
    // then isolate the lowest set bit and encode its index
    always_comb begin
        mask     = ~((N'(1) << ptr) - N'(1));
        masked   = req & mask;
        pick_src = (|masked) ? masked : req;
        gnt      = pick_src & (~pick_src + N'(1));
        gnt_idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = PW'(i);
            end
        end
    end

endmodule

// File: rtl/utmi_tx_arbiter.sv
// Packet-level arbiter sharing the UTMI transmit byte path among N
// endpoint requesters. One requester is granted per packet in
// round-robin order; its bytes are forwarded with a ready/valid
// handshake. Packets longer than MAX_PKT are cut off, and an idle gap
// of GAP_CYC cycles follows every packet.
//
// Optional build macro: UTMI_TX_EP0_PRIO_EN
//   defined   - requester 0 wins every arbitration it takes part in and
//               an ep0 packet leaves the round-robin pointer untouched.
//   undefined - pure round-robin across all N requesters.

module utmi_tx_arbiter
    import utmi_tx_arb_pkg::*;
#(
    parameter int W       = 8,
    parameter int N       = 4,
    parameter int GAP_CYC = 2,
    parameter int MAX_PKT = 64
) (
    input  logic           clk_60mhz,
    input  logic           rst,
    input  logic [N-1:0]   ep_req,
    input  logic [N*W-1:0] ep_data,
    input  logic [N-1:0]   ep_valid,
    input  logic [N-1:0]   ep_last,
    output logic [N-1:0]   ep_ready,
    output logic [N-1:0]   ep_grant,
    output logic [W-1:0]   tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic           busy,
    output logic           pkt_done,
    output logic           len_err
);

    localparam int PW  = cnt_width(N - 1);
    localparam int BCW = cnt_width(MAX_PKT);
    localparam int GCW = cnt_width(GAP_CYC);

    arb_state_t     state;
    arb_state_t     state_nxt;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  g_idx;
    logic [BCW-1:0] byte_cnt;
    logic [GCW-1:0] gap_cnt;

    logic [N-1:0]   pick_gnt;
    logic [PW-1:0]  pick_idx;
    logic [N-1:0]   win_gnt;
    logic [PW-1:0]  win_idx;

    logic           cur_last;
    logic           xfer_fire;
    logic           at_max;
    logic           pkt_end;
    logic           gap_done;
    logic           rr_advance;
    logic [PW-1:0]  rr_next;

    utmi_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req     (ep_req),
        .ptr     (rr_ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

`ifdef UTMI_TX_EP0_PRIO_EN
    // Requester 0 overrides the round-robin choice, and its packets do
    // not move the pointer so the others keep their place in line
    always_comb begin
        win_gnt    = pick_gnt;
        win_idx    = pick_idx;
        rr_advance = (g_idx != '0);
        if (ep_req[0]) begin
            win_gnt = N'(1);
            win_idx = '0;
        end
    end
`else
    // Plain round-robin: the picker result is the winner and every
    // finished packet moves the pointer past its owner
    always_comb begin
        win_gnt    = pick_gnt;
        win_idx    = pick_idx;
        rr_advance = 1'b1;
    end
`endif

    // Pointer position just past the current owner, wrapping at N
    always_comb begin
        rr_next = (g_idx == PW'(N - 1)) ? '0 : g_idx + PW'(1);
    end

    // State register
    always_ff @(posedge clk_60mhz or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the combinational transmit path: the granted
    // lane is muxed straight through, and the end of a packet is either
    // its last byte or the MAX_PKT-th byte, whichever comes first
    always_comb begin
        state_nxt = state;
        tx_data   = '0;
        tx_valid  = 1'b0;
        cur_last  = 1'b0;
        ep_ready  = '0;
        busy      = (state != IDLE);
        if (state == XFER) begin
            for (int i = 0; i < N; i++) begin
                if (ep_grant[i]) begin
                    tx_data  = ep_data[i*W +: W];
                    tx_valid = ep_valid[i];
                    cur_last = ep_last[i];
                end
            end
            ep_ready = ep_grant & {N{tx_ready}};
        end
        xfer_fire = tx_valid && tx_ready;
        at_max    = (byte_cnt == BCW'(MAX_PKT - 1));
        pkt_end   = xfer_fire && (cur_last || at_max);
        gap_done  = (gap_cnt == GCW'(GAP_CYC - 1));
        case (state)
            IDLE: begin
                if (|ep_req) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (pkt_end) begin
                    state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant, counters, round-robin pointer and the end-of-packet pulses
    always_ff @(posedge clk_60mhz or posedge rst) begin
        if (rst) begin
            ep_grant <= '0;
            g_idx    <= '0;
            rr_ptr   <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            pkt_done <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            len_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|ep_req) begin
                        ep_grant <= win_gnt;
                        g_idx    <= win_idx;
                        byte_cnt <= '0;
                    end
                end
                XFER: begin
                    if (xfer_fire) begin
                        byte_cnt <= byte_cnt + BCW'(1);
                    end
                    if (pkt_end) begin
                        ep_grant <= '0;
                        byte_cnt <= '0;
                        gap_cnt  <= '0;
                        pkt_done <= cur_last;
                        len_err  <= !cur_last;
                        if (rr_advance) begin
                            rr_ptr <= rr_next;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_done ? '0 : gap_cnt + GCW'(1);
                end
                default: begin
                    gap_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_utmi_tx_arbiter.sv
// Self-checking bench for utmi_tx_arbiter (N=4, W=8, GAP_CYC=2, MAX_PKT=8).
// Directed packets from a vector table and hand sequences, then a
// randomized run against a cycle-level behavioural model of requesters,
// arbitration order, packet lengths and the inter-packet gap.

module tb_utmi_tx_arbiter;

    localparam int W       = 8;
    localparam int N       = 4;
    localparam int GAP_CYC = 2;
    localparam int MAX_PKT = 8;

    logic           clk_60mhz = 1'b0;
    logic           rst       = 1'b1;
    logic [N-1:0]   ep_req    = '0;
    logic [N*W-1:0] ep_data   = '0;
    logic [N-1:0]   ep_valid  = '0;
    logic [N-1:0]   ep_last   = '0;
    logic [N-1:0]   ep_ready;
    logic [N-1:0]   ep_grant;
    logic [W-1:0]   tx_data;
    logic           tx_valid;
    logic           tx_ready  = 1'b0;
    logic           busy;
    logic           pkt_done;
    logic           len_err;

    int n_checks = 0;
    int n_pass   = 0;

    utmi_tx_arbiter #(
        .W       (W),
        .N       (N),
        .GAP_CYC (GAP_CYC),
        .MAX_PKT (MAX_PKT)
    ) dut (
        .clk_60mhz (clk_60mhz),
        .rst       (rst),
        .ep_req    (ep_req),
        .ep_data   (ep_data),
        .ep_valid  (ep_valid),
        .ep_last   (ep_last),
        .ep_ready  (ep_ready),
        .ep_grant  (ep_grant),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .pkt_done  (pkt_done),
        .len_err   (len_err)
    );

    always #5 clk_60mhz = ~clk_60mhz;

    typedef struct packed {
        logic [N-1:0] req;
        int           len;
        int           exp_g;
        int           exp_bytes;
        logic         exp_lenerr;
    } vec_t;

    task automatic applyStimulus(input logic [N-1:0] req, input logic [N*W-1:0] data,
                                 input logic [N-1:0] valid, input logic [N-1:0] last,
                                 input logic txr);
        ep_req   = req;
        ep_data  = data;
        ep_valid = valid;
        ep_last  = last;
        tx_ready = txr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk_60mhz);
    endtask

    function automatic logic [7:0] pat(input int g, input int b);
        return 8'(g * 64 + b * 3 + 5);
    endfunction

    // Granted lane carries the byte, other lanes carry distinct filler
    function automatic logic [N*W-1:0] laneData(input int g, input logic [W-1:0] b);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i*W +: W] = (i == g) ? b : W'(8'hE0 + i);
        end
        return v;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_grant"},   32'(ep_grant), 0);
        checkOutput({tag, "_ready"},   32'(ep_ready), 0);
        checkOutput({tag, "_txvalid"}, 32'(tx_valid), 0);
        checkOutput({tag, "_txdata"},  32'(tx_data),  0);
        checkOutput({tag, "_busy"},    32'(busy),     0);
        checkOutput({tag, "_done"},    32'(pkt_done), 0);
        checkOutput({tag, "_lenerr"},  32'(len_err),  0);
    endtask

    task automatic doReset();
        nextCycle();
        rst = 1'b1;
        applyStimulus('0, '0, '0, '0, 1'b0);
        #1;
        checkAllZero("reset");
        nextCycle();
        rst = 1'b0;
    endtask

    // One packet from an idle arbiter: arbitration cycle, grant cycle with
    // the owner not yet valid, byte stream (optionally stalled), end pulse,
    // remaining gap cycle, then back to idle
    task automatic runPacket(input logic [N-1:0] req, input int len, input int exp_g,
                             input int exp_bytes, input logic exp_lenerr,
                             input int stall_at, input int stall_len);
        logic [N-1:0] gmask;
        logic [N-1:0] others;
        logic [N-1:0] lastv;
        logic         stall;
        int           b;
        int           stalls;
        gmask  = N'(1) << exp_g;
        others = ~gmask;
        nextCycle();
        applyStimulus(req, laneData(exp_g, 8'h00), '0, '0, 1'b1);
        #1;
        checkOutput("pre_grant", 32'(ep_grant), 0);
        checkOutput("pre_busy",  32'(busy),     0);
        nextCycle();
        applyStimulus(req, laneData(exp_g, 8'h00), others, others, 1'b1);
        #1;
        checkOutput("grant",      32'(ep_grant), 32'(gmask));
        checkOutput("grant_busy", 32'(busy),     1);
        checkOutput("grant_txv",  32'(tx_valid), 0);
        b      = 0;
        stalls = 0;
        while (b < exp_bytes) begin
            stall = (b == stall_at) && (stalls < stall_len);
            lastv = others | ((b == len - 1) ? gmask : '0);
            nextCycle();
            applyStimulus(req, laneData(exp_g, pat(exp_g, b)), '1, lastv, !stall);
            #1;
            checkOutput("tx_valid", 32'(tx_valid), 1);
            checkOutput("tx_data",  32'(tx_data),  32'(pat(exp_g, b)));
            checkOutput("ep_ready", 32'(ep_ready), stall ? 0 : 32'(gmask));
            if (stall) stalls++;
            else       b++;
        end
        nextCycle();
        applyStimulus('0, laneData(exp_g, pat(exp_g, b)), exp_lenerr ? gmask : '0, '0, 1'b1);
        #1;
        checkOutput("end_grant",  32'(ep_grant), 0);
        checkOutput("end_txv",    32'(tx_valid), 0);
        checkOutput("end_ready",  32'(ep_ready), 0);
        checkOutput("end_done",   32'(pkt_done), 32'(!exp_lenerr));
        checkOutput("end_lenerr", 32'(len_err),  32'(exp_lenerr));
        nextCycle();
        applyStimulus('0, '0, '0, '0, 1'b1);
        #1;
        checkOutput("gap_busy",   32'(busy),     1);
        checkOutput("gap_txv",    32'(tx_valid), 0);
        checkOutput("gap_done",   32'(pkt_done), 0);
        checkOutput("gap_lenerr", 32'(len_err),  0);
        nextCycle();
        #1;
        checkOutput("idle_busy", 32'(busy), 0);
    endtask

    // Reference arbitration: first requester at or after rr, wrapping
    function automatic int pickWinner(input logic [N-1:0] req, input int rr);
`ifdef UTMI_TX_EP0_PRIO_EN
        if (req[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (req[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    // Randomized traffic against the behavioural model
    task automatic runRandom(input int cycles);
        int             has_pkt [N];
        int             pkt_len [N];
        int             pos     [N];
        logic [7:0]     bytes   [N][16];
        logic [N-1:0]   req_v, valid_v, last_v;
        logic [N*W-1:0] data_v;
        logic           txr;
        int             m_owner, m_gap, m_cnt, m_end, m_rr;
        logic [N-1:0]   exp_grant, exp_ready;
        logic           exp_txv, finished;
        for (int i = 0; i < N; i++) begin
            has_pkt[i] = 0;
            pkt_len[i] = 0;
            pos[i]     = 0;
        end
        m_owner = -1; m_gap = 0; m_cnt = 0; m_end = 0; m_rr = 0;
        for (int c = 0; c < cycles; c++) begin
            nextCycle();
            for (int i = 0; i < N; i++) begin
                if (has_pkt[i] == 0 && $urandom_range(0, 3) == 0) begin
                    has_pkt[i] = 1;
                    pkt_len[i] = int'($urandom_range(1, 12));
                    pos[i]     = 0;
                    for (int k = 0; k < 16; k++) bytes[i][k] = 8'($urandom);
                end
            end
            for (int i = 0; i < N; i++) begin
                req_v[i]   = (has_pkt[i] != 0) && !(m_owner == i && $urandom_range(0, 3) == 0);
                valid_v[i] = (has_pkt[i] != 0) && ($urandom_range(0, 4) != 0);
                last_v[i]  = (has_pkt[i] != 0) && (pos[i] == pkt_len[i] - 1);
                data_v[i*W +: W] = (has_pkt[i] != 0) ? bytes[i][pos[i]] : 8'($urandom);
            end
            txr = ($urandom_range(0, 3) != 0);
            applyStimulus(req_v, data_v, valid_v, last_v, txr);
            #1;
            exp_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
            exp_txv   = (m_owner >= 0) && valid_v[m_owner];
            exp_ready = (m_owner >= 0 && txr) ? N'(1) << m_owner : '0;
            checkOutput("rnd_grant",  32'(ep_grant), 32'(exp_grant));
            checkOutput("rnd_txv",    32'(tx_valid), 32'(exp_txv));
            checkOutput("rnd_ready",  32'(ep_ready), 32'(exp_ready));
            checkOutput("rnd_busy",   32'(busy),     32'(m_owner >= 0 || m_gap > 0));
            checkOutput("rnd_done",   32'(pkt_done), 32'(m_end == 1));
            checkOutput("rnd_lenerr", 32'(len_err),  32'(m_end == 2));
            if (exp_txv) begin
                checkOutput("rnd_data", 32'(tx_data), 32'(bytes[m_owner][pos[m_owner]]));
            end
            m_end    = 0;
            finished = 1'b0;
            if (m_owner >= 0) begin
                if (valid_v[m_owner] && txr) begin
                    m_cnt++;
                    pos[m_owner]++;
                    if (last_v[m_owner]) begin
                        m_end    = 1;
                        finished = 1'b1;
                    end else if (m_cnt == MAX_PKT) begin
                        m_end    = 2;
                        finished = 1'b1;
                    end
                end
                if (finished) begin
                    has_pkt[m_owner] = 0;
`ifdef UTMI_TX_EP0_PRIO_EN
                    if (m_owner != 0) m_rr = (m_owner + 1) % N;
`else
                    m_rr = (m_owner + 1) % N;
`endif
                    m_owner = -1;
                    m_gap   = GAP_CYC;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (req_v != '0) begin
                m_owner = pickWinner(req_v, m_rr);
                m_cnt   = 0;
            end
        end
    endtask

    vec_t vecs [7];
    int   exp_rr2 [5];
    int   exp_alt [3];

    initial begin
        vecs[0] = '{req: 4'b0110, len: 2,  exp_g: 1, exp_bytes: 2, exp_lenerr: 1'b0};
        vecs[1] = '{req: 4'b1010, len: 1,  exp_g: 3, exp_bytes: 1, exp_lenerr: 1'b0};
        vecs[2] = '{req: 4'b1110, len: 8,  exp_g: 1, exp_bytes: 8, exp_lenerr: 1'b0};
        vecs[3] = '{req: 4'b0010, len: 10, exp_g: 1, exp_bytes: 8, exp_lenerr: 1'b1};
        vecs[4] = '{req: 4'b1100, len: 3,  exp_g: 2, exp_bytes: 3, exp_lenerr: 1'b0};
        vecs[5] = '{req: 4'b0110, len: 1,  exp_g: 1, exp_bytes: 1, exp_lenerr: 1'b0};
        vecs[6] = '{req: 4'b1000, len: 9,  exp_g: 3, exp_bytes: 8, exp_lenerr: 1'b1};
`ifdef UTMI_TX_EP0_PRIO_EN
        exp_rr2 = '{0, 0, 0, 0, 0};
        exp_alt = '{0, 0, 0};
`else
        exp_rr2 = '{0, 1, 2, 3, 0};
        exp_alt = '{3, 0, 3};
`endif

        $display("[TB] utmi_tx_arbiter bench start");
        doReset();

        // Single 3-byte packet from ep2
        runPacket(4'b0100, 3, 2, 3, 1'b0, -1, 0);

        // All four requesting, 1-byte packets, pointer from zero
        doReset();
        for (int k = 0; k < 5; k++) begin
            runPacket(4'b1111, 1, exp_rr2[k], 1, 1'b0, -1, 0);
        end

        // tx_ready held low for 5 cycles after two bytes of a 5-byte packet
        runPacket(4'b0100, 5, 2, 5, 1'b0, 2, 5);

        // Reset in the middle of a packet, then pointer back at ep0
        nextCycle();
        applyStimulus(4'b0100, laneData(2, 8'h00), '0, '0, 1'b1);
        nextCycle();
        applyStimulus(4'b0100, laneData(2, 8'h00), '0, '0, 1'b1);
        #1;
        checkOutput("rst_pre_grant", 32'(ep_grant), 32'(4'b0100));
        for (int b = 0; b < 2; b++) begin
            nextCycle();
            applyStimulus(4'b0100, laneData(2, pat(2, b)), 4'b0100, '0, 1'b1);
            #1;
            checkOutput("rst_pre_data", 32'(tx_data), 32'(pat(2, b)));
        end
        nextCycle();
        applyStimulus(4'b0100, laneData(2, pat(2, 2)), 4'b0100, '0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("async_rst");
        applyStimulus('0, '0, '0, '0, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        runPacket(4'b1111, 2, 0, 2, 1'b0, -1, 0);

        // Bring the pointer to 3, then ep0/ep3 contending
        runPacket(4'b0100, 1, 2, 1, 1'b0, -1, 0);
        for (int k = 0; k < 3; k++) begin
            runPacket(4'b1001, 1, exp_alt[k], 1, 1'b0, -1, 0);
        end

        // Vector table from a fresh pointer
        doReset();
        for (int v = 0; v < 7; v++) begin
            runPacket(vecs[v].req, vecs[v].len, vecs[v].exp_g, vecs[v].exp_bytes,
                      vecs[v].exp_lenerr, -1, 0);
        end

        // Randomized traffic
        doReset();
        runRandom(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
